// File: rtl/cond_logic_pkg.sv
// Shared encodings for the conditional-execution stage: ARM condition codes,
// NZCV bit positions and FlagW field positions.
package cond_logic_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational condition evaluator: Cond against {N,Z,C,V}.
// Shared with the multi-cycle and pipelined controllers.
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx,
  output logic       CondUndef
);

  logic n_s, z_s, c_s, v_s, ge_s;

  assign n_s  = Flags[FLAG_N];
  assign z_s  = Flags[FLAG_Z];
  assign c_s  = Flags[FLAG_C];
  assign v_s  = Flags[FLAG_V];
  assign ge_s = (n_s == v_s);

  // Condition decode; the reserved NV encoding never executes
  always_comb begin
    CondEx    = 1'b0;
    CondUndef = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z_s;
      COND_NE: CondEx = ~z_s;
      COND_CS: CondEx = c_s;
      COND_CC: CondEx = ~c_s;
      COND_MI: CondEx = n_s;
      COND_PL: CondEx = ~n_s;
      COND_VS: CondEx = v_s;
      COND_VC: CondEx = ~v_s;
      COND_HI: CondEx = c_s & ~z_s;
      COND_LS: CondEx = ~c_s | z_s;
      COND_GE: CondEx = ge_s;
      COND_LT: CondEx = ~ge_s;
      COND_GT: CondEx = ~z_s & ge_s;
      COND_LE: CondEx = z_s | ~ge_s;
      COND_AL: CondEx = 1'b1;
      COND_NV: begin
        CondEx    = 1'b0;
        CondUndef = 1'b1;
      end
      default: begin
        CondEx    = 1'b0;
        CondUndef = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: stored NZCV flags, condition gating of the
// decoder write requests, and executed/squashed instruction counters.
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic             CondUndef,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SkipCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       flags_r;
  logic [CNT_W-1:0] exec_cnt_r;
  logic [CNT_W-1:0] skip_cnt_r;
  logic             cond_ex_s;
  logic             cond_undef_s;
  logic             upd_s;

  // Evaluated on the stored flags only, so there is no ALUFlags bypass
  cond_check u_cond_check (
    .Cond      (Cond),
    .Flags     (flags_r),
    .CondEx    (cond_ex_s),
    .CondUndef (cond_undef_s)
  );

  assign upd_s = En & cond_ex_s;

  // NZCV register: each half written independently under FlagW
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_r <= 4'b0000;
    end else if (upd_s) begin
      if (FlagW[FW_NZ]) begin
        flags_r[FLAG_N] <= ALUFlags[FLAG_N];
        flags_r[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagW[FW_CV]) begin
        flags_r[FLAG_C] <= ALUFlags[FLAG_C];
        flags_r[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  // Exactly one counter advances per valid instruction; both wrap silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_cnt_r <= {CNT_W{1'b0}};
      skip_cnt_r <= {CNT_W{1'b0}};
    end else if (En) begin
      if (cond_ex_s) begin
        exec_cnt_r <= exec_cnt_r + CNT_ONE;
      end else begin
        skip_cnt_r <= skip_cnt_r + CNT_ONE;
      end
    end
  end

  assign PCSrc     = PCS & cond_ex_s;
  assign RegWrite  = RegW & cond_ex_s & ~NoWrite;
  assign MemWrite  = MemW & cond_ex_s;
  assign CondEx    = cond_ex_s;
  assign CondUndef = cond_undef_s;
  assign Flags     = flags_r;
  assign ExecCnt   = exec_cnt_r;
  assign SkipCnt   = skip_cnt_r;

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic, built with 4-bit counters so
// counter wrap is reachable in a few edges.
module tb_cond_logic;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             En;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS, RegW, MemW, NoWrite;
  logic             PCSrc, RegWrite, MemWrite, CondEx, CondUndef;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCnt, SkipCnt;

  int errors = 0;
  int checks = 0;
  int exp_exec = 0;
  int exp_skip = 0;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .En(En), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .CondUndef(CondUndef), .ExecCnt(ExecCnt), .SkipCnt(SkipCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".exec"}, 32'(ExecCnt), 32'(exp_exec % 16));
    chk({tag, ".skip"}, 32'(SkipCnt), 32'(exp_skip % 16));
  endtask

  // Reference condition table written directly from the ARM definitions
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return !(n ^ v);
      4'd11: return n ^ v;
      4'd12: return !z && !(n ^ v);
      4'd13: return z || (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Load the flag register with an AL instruction writing all four flags
  task automatic load_flags(input logic [3:0] f);
    En = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    tick();
    exp_exec++;
  endtask

  initial begin
    reset = 1'b1; En = 1'b0; Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst.flags", 32'(Flags), 32'h0);
    chk_cnt("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    // 1: after release, EQ fails on zero flags, all writes gated
    chk("t1.condex", 32'(CondEx), 32'h0);
    chk("t1.pcsrc", 32'(PCSrc), 32'h0);
    chk("t1.regwrite", 32'(RegWrite), 32'h0);
    chk("t1.memwrite", 32'(MemWrite), 32'h0);
    chk("t1.undef", 32'(CondUndef), 32'h0);
    chk("t1.flags", 32'(Flags), 32'h0);
    chk_cnt("t1");

    // 2: AL sets Z, next instruction sees it
    En = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    #1;
    chk("t2.condex", 32'(CondEx), 32'h1);
    chk("t2.pcsrc", 32'(PCSrc), 32'h1);
    chk("t2.regwrite", 32'(RegWrite), 32'h1);
    chk("t2.memwrite", 32'(MemWrite), 32'h1);
    tick(); exp_exec++;
    chk("t2.flags", 32'(Flags), 32'h4);
    chk_cnt("t2");
    En = 1'b0; Cond = 4'b0000; #1;
    chk("t2.eq", 32'(CondEx), 32'h1);
    NoWrite = 1'b1; #1;
    chk("t2.nowrite.regwrite", 32'(RegWrite), 32'h0);
    chk("t2.nowrite.pcsrc", 32'(PCSrc), 32'h1);
    NoWrite = 1'b0;
    Cond = 4'b0001; #1;
    chk("t2.ne", 32'(CondEx), 32'h0);

    // 3: failed EQ squashes writes and flag update
    load_flags(4'b0000);
    chk("t3.pre", 32'(Flags), 32'h0);
    En = 1'b1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1'b1;
    #1;
    chk("t3.condex", 32'(CondEx), 32'h0);
    chk("t3.regwrite", 32'(RegWrite), 32'h0);
    chk("t3.pcsrc", 32'(PCSrc), 32'h0);
    chk("t3.memwrite", 32'(MemWrite), 32'h0);
    tick(); exp_skip++;
    chk("t3.flags", 32'(Flags), 32'h0);
    chk_cnt("t3");

    // 4: partial flag writes
    load_flags(4'b0011);
    FlagW = 2'b10; ALUFlags = 4'b1011;
    tick(); exp_exec++;
    chk("t4.nz", 32'(Flags), 32'hB);
    FlagW = 2'b01; ALUFlags = 4'b0100;
    tick(); exp_exec++;
    chk("t4.cv", 32'(Flags), 32'h8);
    FlagW = 2'b00; ALUFlags = 4'b0111;
    tick(); exp_exec++;
    chk("t4.none", 32'(Flags), 32'h8);
    chk_cnt("t4");

    // Flag-setting conditional instructions evaluate on the old flags
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick(); exp_skip++;
    chk("sim.eq_skip", 32'(Flags), 32'h8);
    Cond = 4'b0001;
    tick(); exp_exec++;
    chk("sim.ne_exec", 32'(Flags), 32'h4);
    ALUFlags = 4'b0000;
    tick(); exp_skip++;
    chk("sim.ne_skip", 32'(Flags), 32'h4);
    chk_cnt("sim");

    // 5: full condition sweep
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      chk("t5.flags", 32'(Flags), 32'(f));
      En = 1'b0;
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1;
        chk($sformatf("t5.condex c=%0d f=%0d", c, f), 32'(CondEx), 32'(ref_cond(4'(c), 4'(f))));
        chk($sformatf("t5.undef c=%0d f=%0d", c, f), 32'(CondUndef), (c == 15) ? 32'h1 : 32'h0);
      end
    end
    chk_cnt("t5");

    // 6: stalls hold everything, including with X on Cond
    En = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0000;
    tick(); tick(); tick();
    chk("t6.stall.flags", 32'(Flags), 32'hF);
    chk_cnt("t6.stall");
    Cond = 4'bxxxx;
    tick();
    chk("t6.x.flags", 32'(Flags), 32'hF);
    chk_cnt("t6.x");

    // Counter wrap
    En = 1'b1; Cond = 4'b1110; FlagW = 2'b00;
    while ((exp_exec % 16) != 15) begin
      tick(); exp_exec++;
    end
    chk("t6.exec_ones", 32'(ExecCnt), 32'hF);
    tick(); exp_exec++;
    chk("t6.exec_wrap", 32'(ExecCnt), 32'h0);
    Cond = 4'b1111; #1;
    chk("t6.nv.undef", 32'(CondUndef), 32'h1);
    while ((exp_skip % 16) != 0) begin
      tick(); exp_skip++;
    end
    chk("t6.skip_wrap", 32'(SkipCnt), 32'h0);
    chk_cnt("t6.wrap");

    // Async reset between edges
    load_flags(4'b1010);
    chk("t6.prereset", 32'(Flags), 32'hA);
    En = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_exec = 0; exp_skip = 0;
    chk("t6.async.flags", 32'(Flags), 32'h0);
    chk_cnt("t6.async");
    #1 reset = 1'b1;
    load_flags(4'b0110);
    chk("t6.post.flags", 32'(Flags), 32'h6);
    chk_cnt("t6.post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
